// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Four-line interrupt controller with a single-level (non-nesting) service
// sequence and flag save/restore for the CPU.
//
// Rising edges on irq[3:0] set per-line pending bits. While the controller is
// idle, an instruction boundary (instr_done) with the global enable (gie) set
// and at least one unmasked pending line starts a sequence. The lowest-index
// unmasked pending line wins. Its vector is presented on int_vec, and the live
// carry/zero flags are captured. The sequence then runs through these states:
//   WAIT_ACK : int_req is high until the CPU acknowledges with int_ack. If no
//              ack arrives within ACK_TIMEOUT cycles, the sequence aborts:
//              ack_err sets (sticky), the pending bit is kept, and the
//              controller returns to IDLE.
//   SERVICE  : the handler is running (active=1). This state ends on reti.
//   RESTORE  : iwe pulses for one cycle while intc_o/intz_o carry the saved
//              flags. The controller then returns to IDLE.
//
// Handshake: int_req is a level that stays high while the controller is in
// WAIT_ACK, and int_vec is stable for the whole of that time. int_ack is
// sampled only in WAIT_ACK, and reti is sampled only in SERVICE; both are
// ignored in every other state.
//
// clock_en=0 freezes every register. Reset (rst, synchronous, active low)
// applies whatever the value of clock_en.
//
// Ports
//   clk, rst, clock_en       clock, synchronous active-low reset, clock enable
//   irq[3:0], irq_mask[3:0]  request lines (edge-detected), per-line enable
//   gie, instr_done          global enable, instruction-boundary pulse
//   int_ack, reti            CPU vector-load acknowledge, return-from-interrupt
//   c_i, z_i                 live carry / zero flags
//   int_req, int_vec[7:0]    request to CPU and vector address
//   active, active_id[1:0]   handler in progress and its id
//   iwe, intc_o, intz_o      flag-restore write enable and saved flags
//   ack_err                  sticky acknowledge-timeout error
// The FSM state can be observed hierarchically as state_q.
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter logic [7:0]  VEC_BASE    = 8'hF0,
  parameter int unsigned VEC_STRIDE  = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clock_en,
  input  logic [3:0] irq,
  input  logic [3:0] irq_mask,
  input  logic       gie,
  input  logic       instr_done,
  input  logic       int_ack,
  input  logic       reti,
  input  logic       c_i,
  input  logic       z_i,
  output logic       int_req,
  output logic [7:0] int_vec,
  output logic       active,
  output logic [1:0] active_id,
  output logic       iwe,
  output logic       intc_o,
  output logic       intz_o,
  output logic       ack_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    SERVICE  = 2'd2,
    RESTORE  = 2'd3
  } state_e;

  localparam logic [3:0] TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);
  localparam logic [7:0] STRIDE8      = 8'(VEC_STRIDE);

  state_e     state_q, state_d;
  logic [3:0] irq_q;
  logic       armed_q;
  logic [3:0] pend_q, pend_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] id_q, id_d;
  logic [7:0] vec_q, vec_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       err_q, err_d;

  logic [3:0] rise;
  logic [3:0] cand;
  logic [3:0] clr;
  logic [1:0] win_id;
  logic [7:0] win_vec;

  // armed_q is low for the first enabled cycle after reset. During that cycle
  // irq_q loads the current line levels. As a result, a line that is already
  // high when reset releases is not taken as a new edge.
  assign rise = irq & ~irq_q & {4{armed_q}};
  assign cand = pend_q & irq_mask;

  // Fixed priority: the lowest index wins. The loop runs downward so that the
  // last assignment made comes from the lowest set bit.
  always_comb begin
    win_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cand[i]) win_id = 2'(i);
    end
  end

  assign win_vec = VEC_BASE + (STRIDE8 * {6'd0, win_id});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    vec_d   = vec_q;
    c_d     = c_q;
    z_d     = z_q;
    err_d   = err_q;
    clr     = 4'd0;
    unique case (state_q)
      IDLE: begin
        if (gie && instr_done && (|cand)) begin
          id_d    = win_id;
          vec_d   = win_vec;
          c_d     = c_i;
          z_d     = z_i;
          cnt_d   = 4'd0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // If the ack arrives on the same cycle as the timeout, the ack wins.
        if (int_ack) begin
          clr     = 4'd1 << id_q;
          state_d = SERVICE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SERVICE: begin
        if (reti) state_d = RESTORE;
      end
      RESTORE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // When a new edge coincides with the acknowledge clear, the set wins.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      irq_q   <= 4'd0;
      armed_q <= 1'b0;
      pend_q  <= 4'd0;
      cnt_q   <= 4'd0;
      id_q    <= 2'd0;
      vec_q   <= 8'h00;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
    end else if (clock_en) begin
      state_q <= state_d;
      irq_q   <= irq;
      armed_q <= 1'b1;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
      c_q     <= c_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  assign int_req   = (state_q == WAIT_ACK);
  assign active    = (state_q == SERVICE) || (state_q == RESTORE);
  assign iwe       = (state_q == RESTORE);
  assign int_vec   = vec_q;
  assign active_id = id_q;
  assign intc_o    = c_q;
  assign intz_o    = z_q;
  assign ack_err   = err_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  localparam int TIMEOUT = 15;
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_SERVE = 2, PH_RESTORE = 3;

  logic       clk = 1'b0;
  logic       rst, clock_en, gie, instr_done, int_ack, reti, c_i, z_i;
  logic [3:0] irq, irq_mask;
  logic       int_req, active, iwe, intc_o, intz_o, ack_err;
  logic [7:0] int_vec;
  logic [1:0] active_id;

  int checks = 0;
  int failures = 0;

  // Reference model: the controller described as phases and plain integers.
  int       m_phase, m_waited, m_id, m_vec;
  bit [3:0] m_pend, m_prev;
  bit       m_armed, m_c, m_z, m_err;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .clk(clk), .rst(rst), .clock_en(clock_en), .irq(irq), .irq_mask(irq_mask),
    .gie(gie), .instr_done(instr_done), .int_ack(int_ack), .reti(reti),
    .c_i(c_i), .z_i(z_i), .int_req(int_req), .int_vec(int_vec),
    .active(active), .active_id(active_id), .iwe(iwe), .intc_o(intc_o),
    .intz_o(intz_o), .ack_err(ack_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_waited = 0; m_id = 0; m_vec = 0;
    m_pend = 0; m_prev = 0; m_armed = 0; m_c = 0; m_z = 0; m_err = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs that are
  // present at the edge.
  task automatic model_step();
    bit [3:0] p, e;
    int first;
    if (!rst) begin
      model_reset();
    end else if (clock_en) begin
      p = m_pend;
      e = 0;
      for (int i = 0; i < 4; i++)
        if (m_armed && irq[i] && !m_prev[i]) e[i] = 1'b1;
      case (m_phase)
        PH_IDLE: begin
          first = -1;
          for (int i = 3; i >= 0; i--) if (p[i] && irq_mask[i]) first = i;
          if (gie && instr_done && first >= 0) begin
            m_id = first;
            m_vec = (240 + 4 * first) % 256;
            m_c = c_i; m_z = z_i;
            m_waited = 0;
            m_phase = PH_WAIT;
          end
        end
        PH_WAIT: begin
          if (int_ack) begin
            p[m_id] = 1'b0;
            m_phase = PH_SERVE;
          end else begin
            m_waited++;
            if (m_waited == TIMEOUT) begin
              m_err = 1'b1;
              m_phase = PH_IDLE;
            end
          end
        end
        PH_SERVE:   if (reti) m_phase = PH_RESTORE;
        default:    m_phase = PH_IDLE;
      endcase
      m_pend = p | e;
      m_prev = irq;
      m_armed = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".int_req"},   8'(int_req),   8'(m_phase == PH_WAIT));
    chk({tag, ".active"},    8'(active),    8'(m_phase == PH_SERVE || m_phase == PH_RESTORE));
    chk({tag, ".iwe"},       8'(iwe),       8'(m_phase == PH_RESTORE));
    chk({tag, ".int_vec"},   int_vec,       8'(m_vec));
    chk({tag, ".active_id"}, 8'(active_id), 8'(m_id));
    chk({tag, ".intc_o"},    8'(intc_o),    8'(m_c));
    chk({tag, ".intz_o"},    8'(intz_o),    8'(m_z));
    chk({tag, ".ack_err"},   8'(ack_err),   8'(m_err));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; clock_en = 1'b1; irq = 4'd0; irq_mask = 4'hF; gie = 1'b1;
    instr_done = 1'b0; int_ack = 1'b0; reti = 1'b0; c_i = 1'b0; z_i = 1'b0;
    model_reset();

    // Reset state
    tick("rst"); tick("rst");
    chk("rst.int_vec", int_vec, 8'h00);
    chk("rst.int_req", 8'(int_req), 8'd0);
    rst = 1'b1;
    tick("arm");

    // Single request on line 2 with the flags captured
    irq = 4'b0100; tick("r19_edge");
    c_i = 1'b1; z_i = 1'b0; instr_done = 1'b1; tick("r19_entry");
    instr_done = 1'b0; c_i = 1'b0; z_i = 1'b1;
    chk("r19.int_req", 8'(int_req), 8'd1);
    chk("r19.int_vec", int_vec, 8'hF8);
    chk("r19.intc", 8'(intc_o), 8'd1);
    chk("r19.intz", 8'(intz_o), 8'd0);
    int_ack = 1'b1; tick("r19_ack");
    int_ack = 1'b0; reti = 1'b1; tick("r19_reti");
    reti = 1'b0;
    chk("r19.iwe", 8'(iwe), 8'd1);
    tick("r19_restore_done");
    chk("r19.iwe_once", 8'(iwe), 8'd0);
    irq = 4'd0; tick("r19_fall");

    // Lines 0 and 3 rise together: line 0 is serviced first, then line 3
    irq = 4'b1001; tick("r20_edge");
    instr_done = 1'b1; tick("r20_entry0");
    instr_done = 1'b0;
    chk("r20.vec0", int_vec, 8'hF0);
    int_ack = 1'b1; tick("r20_ack0");
    int_ack = 1'b0; reti = 1'b1; tick("r20_reti0");
    reti = 1'b0; instr_done = 1'b1; tick("r20_restore0");
    chk("r20.no_entry_in_restore", 8'(int_req), 8'd0);
    tick("r20_entry3");
    instr_done = 1'b0;
    chk("r20.vec3", int_vec, 8'hFC);
    int_ack = 1'b1; tick("r20_ack3");
    int_ack = 1'b0; reti = 1'b1; tick("r20_reti3");
    reti = 1'b0; tick("r20_restore3");
    irq = 4'd0; tick("r20_fall");

    // Acknowledge timeout
    irq = 4'b0010; tick("r21_edge");
    instr_done = 1'b1; tick("r21_entry");
    instr_done = 1'b0;
    repeat (TIMEOUT - 1) tick("r21_wait");
    chk("r21.req_before_timeout", 8'(int_req), 8'd1);
    tick("r21_timeout");
    chk("r21.ack_err", 8'(ack_err), 8'd1);
    chk("r21.int_req", 8'(int_req), 8'd0);
    instr_done = 1'b1; tick("r21_reentry");
    instr_done = 1'b0;
    chk("r21.reentry_vec", int_vec, 8'hF4);
    chk("r21.reentry_req", 8'(int_req), 8'd1);
    int_ack = 1'b1; tick("r21_ack");
    int_ack = 1'b0; reti = 1'b1; tick("r21_reti");
    reti = 1'b0; tick("r21_restore");
    irq = 4'd0; tick("r21_fall");

    // No nesting: line 1 rises while line 2 is in service
    irq = 4'b0100; instr_done = 1'b1; tick("r22_edge");
    tick("r22_entry2");
    int_ack = 1'b1; tick("r22_ack2");
    int_ack = 1'b0; irq = 4'b0110; tick("r22_edge1");
    tick("r22_service");
    chk("r22.no_req_in_service", 8'(int_req), 8'd0);
    reti = 1'b1; tick("r22_reti");
    reti = 1'b0;
    chk("r22.no_req_restore", 8'(int_req), 8'd0);
    tick("r22_back_idle");
    tick("r22_entry1");
    instr_done = 1'b0;
    chk("r22.vec1", int_vec, 8'hF4);
    int_ack = 1'b1; tick("r22_ack1");
    int_ack = 1'b0; reti = 1'b1; tick("r22_reti1");
    reti = 1'b0; tick("r22_restore1");
    irq = 4'd0; tick("r22_fall");

    // Clock enable low for five cycles in WAIT_ACK while int_ack is held
    irq = 4'b1000; tick("r23_edge");
    instr_done = 1'b1; tick("r23_entry");
    instr_done = 1'b0; clock_en = 1'b0; int_ack = 1'b1;
    repeat (5) tick("r23_frozen");
    chk("r23.still_req", 8'(int_req), 8'd1);
    chk("r23.not_active", 8'(active), 8'd0);
    clock_en = 1'b1; tick("r23_ack");
    int_ack = 1'b0;
    chk("r23.active", 8'(active), 8'd1);
    reti = 1'b1; tick("r23_reti");
    reti = 1'b0; tick("r23_restore");
    irq = 4'd0; tick("r23_fall");

    // Reset during SERVICE with irq[0] held high
    irq = 4'b0001; tick("r24_edge");
    instr_done = 1'b1; tick("r24_entry");
    instr_done = 1'b0; int_ack = 1'b1; tick("r24_ack");
    int_ack = 1'b0; rst = 1'b0; tick("r24_reset");
    chk("r24.active", 8'(active), 8'd0);
    chk("r24.iwe", 8'(iwe), 8'd0);
    chk("r24.int_vec", int_vec, 8'h00);
    chk("r24.active_id", 8'(active_id), 8'd0);
    rst = 1'b1; instr_done = 1'b1;
    repeat (6) begin
      tick("r24_held");
      chk("r24.no_reentry", 8'(int_req), 8'd0);
      chk("r24.no_iwe", 8'(iwe), 8'd0);
    end
    irq = 4'd0; instr_done = 1'b0; tick("r24_fall");

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 99) != 0);
      clock_en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) irq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) irq_mask = 4'($urandom_range(0, 15));
      gie        = ($urandom_range(0, 4) != 0);
      instr_done = 1'($urandom_range(0, 1));
      int_ack    = ($urandom_range(0, 9) < 3);
      reti       = ($urandom_range(0, 9) < 3);
      c_i        = 1'($urandom_range(0, 1));
      z_i        = 1'($urandom_range(0, 1));
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
